// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the immediate fields of an RV32I template instruction.
// Type 110 (LI) expands to LUI+ADDI; `define IMM_ENC_LI_COMPACT_EN collapses LI to one beat when possible.
module imm_encoder (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        in_valid_in,
  output logic        in_ready_out,
  input  logic [31:0] instr_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  imm_type_in,
  output logic        out_valid_out,
  input  logic        out_ready_in,
  output logic [31:0] instr_out,
  output logic        err_out,
  output logic        last_out
);

  typedef enum logic [2:0] {
    T_NONE = 3'b000,
    T_I    = 3'b001,
    T_S    = 3'b010,
    T_B    = 3'b011,
    T_U    = 3'b100,
    T_J    = 3'b101,
    T_LI   = 3'b110,
    T_ISH  = 3'b111
  } imm_type_e;

  typedef enum logic {
    IDLE,
    LI_LO
  } state_e;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  state_e      state_q, state_d;
  logic [4:0]  rd_q;
  logic [11:0] lo_q;

  logic        accept, drain;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [4:0]  li_rd;
  logic [31:0] lui_word;

  logic [31:0] enc_instr;
  logic        enc_err, enc_last, enc_to_lo;

  logic [31:0] instr_d;
  logic        valid_d, err_d, last_d;

  assign in_ready_out = rst_in & (state_q == IDLE) & (!out_valid_out | out_ready_in);
  assign accept       = in_valid_in & in_ready_out;
  assign drain        = out_valid_out & out_ready_in;

  // ADDI sign-extends lo, so the upper part absorbs a carry whenever imm[11] is set.
  assign li_hi    = imm_in[31:12] + 20'(imm_in[11]);
  assign li_lo    = imm_in[11:0];
  assign li_rd    = instr_in[11:7];
  assign lui_word = {li_hi, li_rd, OP_LUI};

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    enc_instr = instr_in;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
    enc_to_lo = 1'b0;
    case (imm_type_e'(imm_type_in))
      T_I, T_ISH: begin
        enc_instr[31:20] = imm_in[11:0];
        enc_err          = imm_in[31:12] != {20{imm_in[11]}};
      end
      T_S: begin
        enc_instr[31:25] = imm_in[11:5];
        enc_instr[11:7]  = imm_in[4:0];
        enc_err          = imm_in[31:12] != {20{imm_in[11]}};
      end
      T_B: begin
        enc_instr[31]    = imm_in[12];
        enc_instr[7]     = imm_in[11];
        enc_instr[30:25] = imm_in[10:5];
        enc_instr[11:8]  = imm_in[4:1];
        enc_err          = (imm_in[31:13] != {19{imm_in[12]}}) | imm_in[0];
      end
      T_U: begin
        enc_instr[31:12] = imm_in[31:12];
        enc_err          = |imm_in[11:0];
      end
      T_J: begin
        enc_instr[31]    = imm_in[20];
        enc_instr[19:12] = imm_in[19:12];
        enc_instr[20]    = imm_in[11];
        enc_instr[30:21] = imm_in[10:1];
        enc_err          = (imm_in[31:21] != {11{imm_in[20]}}) | imm_in[0];
      end
      T_LI: begin
`ifdef IMM_ENC_LI_COMPACT_EN
        if (li_hi == 20'd0) begin
          enc_instr = {li_lo, 5'd0, 3'b000, li_rd, OP_ADDI};
        end else if (li_lo == 12'd0) begin
          enc_instr = lui_word;
        end else begin
          enc_instr = lui_word;
          enc_last  = 1'b0;
          enc_to_lo = 1'b1;
        end
`else
        enc_instr = lui_word;
        enc_last  = 1'b0;
        enc_to_lo = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = out_valid_out;
    instr_d = instr_out;
    err_d   = err_out;
    last_d  = last_out;
    if (accept) begin
      valid_d = 1'b1;
      instr_d = enc_instr;
      err_d   = enc_err;
      last_d  = enc_last;
      state_d = enc_to_lo ? LI_LO : IDLE;
    end else if (state_q == LI_LO && drain) begin
      valid_d = 1'b1;
      instr_d = {lo_q, rd_q, 3'b000, rd_q, OP_ADDI};
      err_d   = 1'b0;
      last_d  = 1'b1;
      state_d = IDLE;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      out_valid_out <= 1'b0;
      instr_out     <= '0;
      err_out       <= 1'b0;
      last_out      <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_out <= valid_d;
      instr_out     <= instr_d;
      err_out       <= err_d;
      last_out      <= last_d;
    end
  end

  // NOTE: the LI operand latches have no reset; they are read only in LI_LO, which reset always leaves.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      rd_q <= li_rd;
      lo_q <= li_lo;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed steps plus a short randomized run,
// with expected beats queued at request time and popped on each output handshake.
module tb_imm_encoder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [31:0] instr_in;
  logic [31:0] imm_in;
  logic [2:0]  imm_type_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [31:0] instr_out;
  logic        err_out;
  logic        last_out;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  bit    rand_bp      = 1'b0;

  imm_encoder dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .instr_in      (instr_in),
    .imm_in        (imm_in),
    .imm_type_in   (imm_type_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .instr_out     (instr_out),
    .err_out       (err_out),
    .last_out      (last_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic err, input logic last);
    beat_t b;
    b.instr = instr;
    b.err   = err;
    b.last  = last;
    exp_q.push_back(b);
  endtask

  // Called at the falling edge: a beat with valid&ready here is consumed at the next rising edge.
  task automatic sb_sample();
    beat_t got, e;
    if (rst_in && out_valid_out && out_ready_in) begin
      got = {instr_out, err_out, last_out};
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL unexpected_beat: observed instr=%h err=%b last=%b expected no beat",
               instr_out, err_out, last_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        assert (got === e) else begin
          tests_failed++;
          $error("FAIL beat: observed instr=%h err=%b last=%b expected instr=%h err=%b last=%b",
                 got.instr, got.err, got.last, e.instr, e.err, e.last);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    sb_sample();
    @(posedge clk_in);
    #1;
    if (rand_bp) out_ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] imm, input logic [2:0] t,
                      output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    instr_in    = instr;
    imm_in      = imm;
    imm_type_in = t;
    in_valid_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      acc = in_ready_out;
      sb_sample();
      @(posedge clk_in);
      #1;
      if (rand_bp) out_ready_in = 1'($urandom_range(0, 1));
      if (acc) break;
      waited++;
    end
    in_valid_in = 1'b0;
    tests_run++;
    assert (acc) else begin
      tests_failed++;
      $error("FAIL accept_timeout: observed no accept expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    out_ready_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    tests_run++;
    assert (exp_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL drain_timeout: observed %0d beats pending expected 0", exp_q.size());
    end
  endtask

  function automatic beat_t model(input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] t);
    beat_t b;
    b.instr = ins;
    b.err   = 1'b0;
    b.last  = 1'b1;
    case (t)
      3'd1, 3'd7: begin
        b.instr[31:20] = imm[11:0];
        b.err = ($signed(imm) < -2048) || ($signed(imm) > 2047);
      end
      3'd2: begin
        b.instr[31:25] = imm[11:5];
        b.instr[11:7]  = imm[4:0];
        b.err = ($signed(imm) < -2048) || ($signed(imm) > 2047);
      end
      3'd3: begin
        b.instr[31] = imm[12];
        b.instr[7]  = imm[11];
        b.instr[30:25] = imm[10:5];
        b.instr[11:8]  = imm[4:1];
        b.err = ($signed(imm) < -4096) || ($signed(imm) > 4095) || imm[0];
      end
      3'd4: begin
        b.instr[31:12] = imm[31:12];
        b.err = imm[11:0] != 12'd0;
      end
      3'd5: begin
        b.instr[31]    = imm[20];
        b.instr[19:12] = imm[19:12];
        b.instr[20]    = imm[11];
        b.instr[30:21] = imm[10:1];
        b.err = ($signed(imm) < -1048576) || ($signed(imm) > 1048575) || imm[0];
      end
      default: ;
    endcase
    return b;
  endfunction

  initial begin
    int    w;
    int    idx;
    beat_t mb;
    logic [31:0] rimm;
    logic [31:0] rins;
    logic [2:0]  tlist [7];
    tlist = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

    rst_in       = 1'b0;
    in_valid_in  = 1'b1;
    out_ready_in = 1'b1;
    instr_in     = 32'h0005_0513;
    imm_in       = 32'h0000_0001;
    imm_type_in  = 3'b001;
    repeat (3) step();
    check("rst_valid", 32'(out_valid_out), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_last", 32'(last_out), 32'd0);
    check("rst_ready", 32'(in_ready_out), 32'd0);
    in_valid_in = 1'b0;
    rst_in = 1'b1;
    step();
    check("idle_ready", 32'(in_ready_out), 32'd1);

    // I encode, one-cycle latency
    push(32'hFFF5_0513, 1'b0, 1'b1);
    send(32'h0005_0513, 32'hFFFF_FFFF, 3'b001, w);
    check("i_latency_valid", 32'(out_valid_out), 32'd1);
    check("i_instr", instr_out, 32'hFFF5_0513);
    drain();

    // Single-beat types, in-range and out-of-range
    push(32'h7E00_0FE3, 1'b0, 1'b1); send(32'h0000_0063, 32'h0000_0FFE, 3'b011, w);
    push(32'h8000_0063, 1'b1, 1'b1); send(32'h0000_0063, 32'h0000_1001, 3'b011, w);
    push(32'h0000_0537, 1'b1, 1'b1); send(32'h0000_0537, 32'h0000_0800, 3'b100, w);
    push(32'h0010_006F, 1'b0, 1'b1); send(32'h0000_006F, 32'h0000_0800, 3'b101, w);
    push(32'h8000_006F, 1'b1, 1'b1); send(32'h0000_006F, 32'h0010_0000, 3'b101, w);
    push(32'hFEA1_2E23, 1'b0, 1'b1); send(32'h00A1_2023, 32'hFFFF_FFFC, 3'b010, w);
    push(32'h8005_0513, 1'b1, 1'b1); send(32'h0005_0513, 32'h0000_0800, 3'b001, w);
    push(32'h0055_1513, 1'b0, 1'b1); send(32'h0005_1513, 32'h0000_0005, 3'b111, w);
    push(32'hDEAD_BEEF, 1'b0, 1'b1); send(32'hDEAD_BEEF, 32'h1234_5678, 3'b000, w);
    drain();

    // LI split into LUI then ADDI
    push(32'h1234_6537, 1'b0, 1'b0);
    push(32'hFFF5_0513, 1'b0, 1'b1);
    send(32'h0000_0500, 32'h1234_5FFF, 3'b110, w);
    check("li_lui_instr", instr_out, 32'h1234_6537);
    check("li_lui_last", 32'(last_out), 32'd0);
    check("li_mid_ready", 32'(in_ready_out), 32'd0);
    step();
    check("li_addi_instr", instr_out, 32'hFFF5_0513);
    check("li_addi_last", 32'(last_out), 32'd1);
    drain();

    // Backpressure hold, then drain and accept in the same cycle
    out_ready_in = 1'b0;
    push(32'h0075_0513, 1'b0, 1'b1);
    send(32'h0005_0513, 32'h0000_0007, 3'b001, w);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_instr", instr_out, 32'h0075_0513);
      check("bp_hold_valid", 32'(out_valid_out), 32'd1);
      check("bp_ready_low", 32'(in_ready_out), 32'd0);
    end
    out_ready_in = 1'b1;
    push(32'h0105_0513, 1'b0, 1'b1);
    send(32'h0005_0513, 32'h0000_0010, 3'b001, w);
    check("bp_same_cycle_accept", 32'(w), 32'd0);
    check("bp_next_valid", 32'(out_valid_out), 32'd1);
    check("bp_next_instr", instr_out, 32'h0105_0513);
    drain();

    // Reset while the LUI beat is held: no ADDI may follow
    out_ready_in = 1'b0;
    send(32'h0000_0500, 32'h1234_5FFF, 3'b110, w);
    check("rli_lui_instr", instr_out, 32'h1234_6537);
    repeat (2) step();
    rst_in = 1'b0;
    step();
    check("rli_valid_cleared", 32'(out_valid_out), 32'd0);
    check("rli_ready_in_reset", 32'(in_ready_out), 32'd0);
    rst_in = 1'b1;
    out_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rli_no_addi", 32'(out_valid_out), 32'd0);
    end
    check("rli_idle_ready", 32'(in_ready_out), 32'd1);

    // LI with a zero upper or zero lower part
`ifdef IMM_ENC_LI_COMPACT_EN
    push(32'h1230_0513, 1'b0, 1'b1);
`else
    push(32'h0000_0537, 1'b0, 1'b0);
    push(32'h1235_0513, 1'b0, 1'b1);
`endif
    send(32'h0000_0500, 32'h0000_0123, 3'b110, w);
    drain();
`ifdef IMM_ENC_LI_COMPACT_EN
    push(32'h0000_5537, 1'b0, 1'b1);
`else
    push(32'h0000_5537, 1'b0, 1'b0);
    push(32'h0005_0513, 1'b0, 1'b1);
`endif
    send(32'h0000_0500, 32'h0000_5000, 3'b110, w);
    drain();

    // Randomized single-beat requests under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 24; i++) begin
      idx  = $urandom_range(0, 6);
      rins = $urandom;
      if ($urandom_range(0, 1) == 0) rimm = 32'($signed(14'($urandom)));
      else                           rimm = $urandom;
      mb = model(rins, rimm, tlist[idx]);
      push(mb.instr, mb.err, mb.last);
      send(rins, rimm, tlist[idx], w);
    end
    rand_bp = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
